// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED pattern controller: mode encodings,
// LED bank width and the prescaler/debounce counter width.
package led_ctrl_pkg;

    localparam int LED_W   = 4;
    localparam int PRESC_W = 24;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_COUNT:  return MODE_SHIFT;
            MODE_SHIFT:  return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_HOLD;
            default:     return MODE_COUNT;
        endcase
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises and debounces one active-low push-button and emits a
// single-cycle pulse when a stable press is accepted.
module button_debouncer
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = 120_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(DEBOUNCE - 1);

    logic               sync1;
    logic               sync2;
    logic               stable;
    logic [PRESC_W-1:0] cnt;

    // The stable value flips on the edge where the counter would reach DEBOUNCE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_controller.sv
// 4-LED pattern sequencer: prescaled step tick, mode/speed selection from
// two debounced buttons, and per-mode LED next-state logic.
module led_pattern_controller
    import led_ctrl_pkg::*;
#(
    parameter int BASE_PERIOD = 12_000_000,
    parameter int DEBOUNCE    = 120_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode_n,
    input  logic             btn_speed_n,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic [1:0]       speed,
    output logic             tick
);

    localparam logic [PRESC_W-1:0] BASE = PRESC_W'(BASE_PERIOD);

    logic               press_mode;
    logic               press_speed;
    logic               any_press;
    logic               at_tc;
    logic               step;
    logic [PRESC_W-1:0] tc;
    logic [PRESC_W-1:0] presc;
    mode_t              cur_mode;
    mode_t              new_mode;
    logic               dir_up;
    logic [LED_W-1:0]   led_step;
    logic               dir_step;

    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_mode_btn (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_mode_n),
        .press (press_mode)
    );

    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_speed_btn (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_speed_n),
        .press (press_speed)
    );

    assign mode = cur_mode;

    // A press on the terminal-count cycle swallows that step entirely
    always_comb begin
        tc        = (BASE >> speed) - 1'b1;
        any_press = press_mode | press_speed;
        at_tc     = (presc == tc);
        step      = at_tc && !any_press;
        new_mode  = next_mode(cur_mode);
    end

    always_comb begin
        led_step = led;
        dir_step = dir_up;
        case (cur_mode)
            MODE_COUNT: led_step = led + 1'b1;
            MODE_SHIFT: led_step = {led[LED_W-2:0], led[LED_W-1]};
            MODE_BOUNCE: begin
                if (dir_up) begin
                    led_step = {led[LED_W-2:0], 1'b0};
                    if (led == 4'b0100) begin
                        dir_step = 1'b0;
                    end
                end else begin
                    led_step = {1'b0, led[LED_W-1:1]};
                    if (led == 4'b0010) begin
                        dir_step = 1'b1;
                    end
                end
            end
            default: led_step = led;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            cur_mode <= MODE_COUNT;
            speed    <= 2'd0;
            led      <= '0;
            dir_up   <= 1'b1;
            tick     <= 1'b0;
        end else begin
            tick <= step;
            if (any_press) begin
                presc <= '0;
                if (press_mode) begin
                    cur_mode <= new_mode;
                    case (new_mode)
                        MODE_COUNT: led <= 4'b0000;
                        MODE_SHIFT: led <= 4'b0001;
                        MODE_BOUNCE: begin
                            led    <= 4'b0001;
                            dir_up <= 1'b1;
                        end
                        default: led <= led;
                    endcase
                end
                if (press_speed) begin
                    speed <= speed + 1'b1;
                end
            end else if (at_tc) begin
                presc  <= '0;
                led    <= led_step;
                dir_up <= dir_step;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: doc/led_pattern_controller.md
# led_pattern_controller

Sequencer for the board's 4-LED bank, driven by two active-low PMOD push-buttons. It owns a shared prescaler that divides the board clock (12 MHz default) into a step tick, and it runs a mode FSM that selects the LED pattern. It debounces both buttons, and it lets the user cycle the pattern mode and the step rate at run time. It sits directly between the PMOD button pins and the `led` outputs at the top level.

## Interface
- `BASE_PERIOD`, default 12_000_000: clock cycles per step at speed 0; must be ≥ 8 and < 2^24.
- `DEBOUNCE`, default 120_000: consecutive stable cycles (10 ms) required before a button change is accepted; must be ≥ 1 and < 2^24.
- `clk` in 1: single clock; all logic is in this domain.
- `rst` in 1: reset; asynchronous assert, active-high.
- `btn_mode_n` in 1: raw mode button; asynchronous, pressed = 0.
- `btn_speed_n` in 1: raw speed button; asynchronous, pressed = 0.
- `led` out 4: LED pattern.
- `mode` out 2: current mode; 0 = COUNT, 1 = SHIFT, 2 = BOUNCE, 3 = HOLD.
- `speed` out 2: current rate select.
- `tick` out 1: one-cycle pulse on each step.

## Operation
- **Reset values:** `led` = 0000, `mode` = COUNT, `speed` = 0, `tick` = 0, bounce direction = up, prescaler = 0, both debounced buttons = released.
- **Button path:**
  - Raw input goes through a 2-flop synchroniser, then a debounce counter.
  - The counter clears whenever the synchronised value equals the stable value.
  - The stable value flips when the counter reaches `DEBOUNCE`.
  - A stable released→pressed flip produces a one-cycle `press` pulse.
  - Releases produce nothing.
- **Prescaler:**
  - Terminal count TC = (`BASE_PERIOD` >> `speed`) − 1.
  - The prescaler counts 0..TC. At TC it reloads 0, and a step occurs.
  - Width is 24 bits, unsigned.
- **Mode press:**
  - Mode advances COUNT→SHIFT→BOUNCE→HOLD→COUNT.
  - `led` loads the new mode's initial pattern: COUNT 0000, SHIFT 0001, BOUNCE 0001 with direction = up, HOLD keeps the current `led`.
  - The prescaler clears.
- **Speed press:**
  - `speed` increments and wraps 3→0.
  - The prescaler clears.
  - `led` and `mode` are unchanged.
- **Step actions per mode:**
  - COUNT: `led` + 1, 4-bit wrap, 1111→0000.
  - SHIFT: rotate left, 1000→0001.
  - BOUNCE (up): shift left. When the result is 1000, the direction becomes down.
  - BOUNCE (down): shift right. When the result is 0001, the direction becomes up.
  - HOLD: no change; `tick` still pulses.
- **Priority:** a press in the same cycle as the prescaler reaching TC wins. The step is dropped: no `tick`, no LED step, prescaler = 0.
- **Simultaneous mode and speed press:** both are applied in the same cycle, with a single prescaler clear.

## Timing
- **Step timing:**
  - At the edge where prescaler = TC, the controller registers `tick` = 1 and the next `led` together.
  - `tick` is high for exactly one cycle, with the new `led` already visible.
  - Step period = TC + 1 cycles.
  - After a reset release or a press clear, the first step comes TC + 1 cycles later.
- **Press latency:**
  - The raw falling edge reaches the synchronised value 2 edges later.
  - The `press` pulse follows `DEBOUNCE` edges after that.
  - `mode`/`speed`/`led` update at the next edge.
- **Press filtering:**
  - A glitch shorter than `DEBOUNCE` synchronised cycles never produces a press.
  - A held button produces exactly one press.
- **Reset:**
  - Assertion forces all registers to their reset values immediately, with no clock needed.
  - Deassertion mid-operation restarts from the reset state; there is no partial state retention.
- **Outputs:** all outputs are registered; there are no combinational paths from input to output.

## Structure
- **Shared include/package `led_ctrl_pkg`:** mode encodings (`MODE_COUNT`..`MODE_HOLD`), the `LED_W` = 4 constant, and the prescaler width 24.
- **One sub-module, `button_debouncer`:** parameter `DEBOUNCE`; ports `clk`, `rst`, `btn_n`, `press`. It contains the synchroniser, the counter and the edge pulse. It is instantiated twice.
- **Top module:** the prescaler, the mode/speed registers and the LED next-state logic.

## Test plan
All scenarios use `BASE_PERIOD` = 16 and `DEBOUNCE` = 4.
1. **Reset, idle:**
   - Release `rst` → `tick` pulses every 16 cycles.
   - `led` goes 0001, 0010, 0011, …; after 16 ticks it is 0000.
   - `mode` = 0, `speed` = 0.
2. **Speed cycling:**
   - One speed press → `speed` = 1, tick period 8; the next tick arrives 8 cycles after the update.
   - Further presses → periods 4 and 2.
   - Fourth press → `speed` = 0, period 16.
3. **Mode sequence:**
   - Press mode → SHIFT, `led` = 0001, then ticks give 0010, 0100, 1000, 0001.
   - Press mode → BOUNCE, ticks give 0010, 0100, 1000, 0100, 0010, 0001, 0010.
   - Press mode → HOLD, `led` is frozen while `tick` keeps pulsing.
   - Press mode → COUNT, `led` = 0000.
4. **Debounce:**
   - `btn_mode_n` low for 3 cycles → no change.
   - Low for 200 cycles → exactly one mode advance, seen 2 + 4 + 1 cycles after the falling edge.
   - Bouncing release → no press.
5. **Collisions:**
   - A press arriving on the cycle the prescaler = TC → no `tick` that cycle, and the next tick comes TC + 1 cycles later.
   - Mode and speed pressed in the same cycle → both registers update together.
6. **Async reset mid-run:**
   - Assert `rst` between clock edges in BOUNCE at `speed` = 2 → all outputs at reset values before the next edge.
   - Release → restart in COUNT with a 16-cycle period.
